// File: rtl/mmio_perf_counters.sv
// Memory-mapped performance counter bank: cycle, retired-instruction, branch and
// correct-branch counters with MMIO clear/freeze control and a combinational read mux.
module mmio_perf_counters #(
    parameter int unsigned          W_SIZE        = 32,
    parameter logic [W_SIZE-1:0]    CNT_RST_ADDR  = 32'h80000018,
    parameter logic [W_SIZE-1:0]    CNT_CTRL_ADDR = 32'h80000024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              w_valid,
    input  logic              br_resolved,
    input  logic              br_mispredict,
    input  logic              mem_we,
    input  logic [W_SIZE-1:0] mem_addr,
    input  logic [W_SIZE-1:0] mem_wdata,
    input  logic [3:0]        wb_sel,
    output logic [W_SIZE-1:0] rd_data,
    output logic [W_SIZE-1:0] cycle_cnt,
    output logic [W_SIZE-1:0] inst_cnt,
    output logic [W_SIZE-1:0] br_cnt,
    output logic [W_SIZE-1:0] corr_br_cnt,
    output logic              frozen
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] FROZEN = 1'b1;

    localparam logic [W_SIZE-1:0] ONE = {{(W_SIZE-1){1'b0}}, 1'b1};

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              clr;
    logic              ctrl_wr;
    logic [W_SIZE-1:0] cycle_d;
    logic [W_SIZE-1:0] inst_d;
    logic [W_SIZE-1:0] br_d;
    logic [W_SIZE-1:0] corr_br_d;

    // Only bit 0 of the control store carries meaning.
    logic unused_wdata;
    assign unused_wdata = ^mem_wdata[W_SIZE-1:1];

    assign clr     = mem_we && (mem_addr == CNT_RST_ADDR);
    assign ctrl_wr = mem_we && (mem_addr == CNT_CTRL_ADDR);
    assign frozen  = (state_q == FROZEN);

    always_comb begin
        state_d = state_q;
        if (ctrl_wr) begin
            state_d = mem_wdata[0] ? FROZEN : RUN;
        end
    end

    // Clear wins over any increment and applies regardless of state.
    always_comb begin
        cycle_d   = cycle_cnt;
        inst_d    = inst_cnt;
        br_d      = br_cnt;
        corr_br_d = corr_br_cnt;
        if (clr) begin
            cycle_d   = '0;
            inst_d    = '0;
            br_d      = '0;
            corr_br_d = '0;
        end else if (state_q == RUN) begin
            cycle_d = cycle_cnt + ONE;
            if (w_valid && !stall) begin
                inst_d = inst_cnt + ONE;
            end
            if (br_resolved && !stall) begin
                br_d = br_cnt + ONE;
                if (!br_mispredict) begin
                    corr_br_d = corr_br_cnt + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cycle_cnt   <= '0;
            inst_cnt    <= '0;
            br_cnt      <= '0;
            corr_br_cnt <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt   <= cycle_d;
            inst_cnt    <= inst_d;
            br_cnt      <= br_d;
            corr_br_cnt <= corr_br_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (wb_sel)
            4'd6:    rd_data = cycle_cnt;
            4'd7:    rd_data = inst_cnt;
            4'd8:    rd_data = br_cnt;
            4'd9:    rd_data = corr_br_cnt;
            default: rd_data = '0;
        endcase
    end

endmodule
